// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the default parameter values, the arbiter FSM state encoding and a
// helper for sizing requester index fields.
package uart_pkg;

  localparam int unsigned NREQ_DEFAULT      = 4;
  localparam int unsigned BYTESIZES_DEFAULT = 8;
  localparam int unsigned MAX_BURST_DEFAULT = 16;

  // Arbiter FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SEND  = 2'd1;
  localparam state_t DRAIN = 2'd2;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
// Searches upward from last_idx+1, wrapping, and returns the first set request.
// Ports:
//   req      - request vector, one bit per requester
//   last_idx - index of the previous owner; the search starts just above it
//   grant    - one-hot winner, all-zero when nothing is requesting
//   found    - high when grant holds a winner
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_idx,
  output logic [NREQ-1:0] grant,
  output logic            found
);

  logic [IDXW-1:0] cand;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    // Offset 1..NREQ so the previous owner is considered last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDXW'((32'(last_idx) + i) % NREQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// A winner keeps the grant until it sends a byte marked last or reaches
// MAX_BURST bytes; bytes pass through a single holding register.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   req_valid_in   - per-requester byte valid
//   req_data_in    - per-requester byte, requester i at [i*BYTESIZES +: BYTESIZES]
//   req_last_in    - per-requester end-of-message marker
//   req_ready_out  - per-requester accept, only ever set for the owner
//   tx_valid_out   - byte valid toward the UART transmitter
//   tx_data_out    - byte toward the UART transmitter
//   tx_ready_in    - UART transmitter ready
//   grant_out      - one-hot current owner, zero when idle
//   busy_out       - high whenever the FSM is not idle
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEFAULT,
  parameter int unsigned BYTESIZES = BYTESIZES_DEFAULT,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid_in,
  input  logic [NREQ*BYTESIZES-1:0] req_data_in,
  input  logic [NREQ-1:0]           req_last_in,
  output logic [NREQ-1:0]           req_ready_out,
  output logic                      tx_valid_out,
  output logic [BYTESIZES-1:0]      tx_data_out,
  input  logic                      tx_ready_in,
  output logic [NREQ-1:0]           grant_out,
  output logic                      busy_out
);

  localparam int unsigned IDXW = idx_width(NREQ);
  localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [IDXW-1:0]      grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]      last_grant_q, last_grant_d;
  logic [BYTESIZES-1:0] hold_data_q, hold_data_d;
  logic                 hold_full_q, hold_full_d;
  logic [CNTW-1:0]      burst_cnt_q, burst_cnt_d;

  logic [NREQ-1:0]      pick_grant;
  logic                 pick_found;
  logic [IDXW-1:0]      pick_idx;

  logic                 sel_valid;
  logic                 sel_last;
  logic [BYTESIZES-1:0] sel_data;
  logic                 req_fire;
  logic                 tx_fire;
  logic [CNTW-1:0]      burst_inc;

  uart_rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req      (req_valid_in),
    .last_idx (last_grant_q),
    .grant    (pick_grant),
    .found    (pick_found)
  );

  // One-hot to index for the picked requester.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) pick_idx = IDXW'(i);
    end
  end

  // Route the owner's request lines.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx_q == IDXW'(i)) begin
        sel_valid = req_valid_in[i];
        sel_last  = req_last_in[i];
        sel_data  = req_data_in[i*BYTESIZES +: BYTESIZES];
      end
    end
  end

  // Ready is only offered while the holding register is empty, so a requester
  // transfer and a TX transfer never coincide.
  assign req_fire  = (state_q == SEND) && !hold_full_q && sel_valid;
  assign tx_fire   = hold_full_q && tx_ready_in;
  assign burst_inc = burst_cnt_q + CNTW'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    hold_data_d  = hold_data_q;
    hold_full_d  = hold_full_q;
    burst_cnt_d  = burst_cnt_q;

    if (tx_fire) hold_full_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_grant;
          grant_idx_d = pick_idx;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (req_fire) begin
          hold_data_d = sel_data;
          hold_full_d = 1'b1;
          if (burst_cnt_q != CNTW'(MAX_BURST)) burst_cnt_d = burst_inc;
          if (sel_last || (burst_inc == CNTW'(MAX_BURST))) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave only once the final byte has gone out.
        if (!hold_full_q) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
          burst_cnt_d  = '0;
          grant_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= IDXW'(NREQ - 1);
      hold_data_q  <= '0;
      hold_full_q  <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      hold_data_q  <= hold_data_d;
      hold_full_q  <= hold_full_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign req_ready_out = ((state_q == SEND) && !hold_full_q) ? grant_q : '0;
  assign tx_valid_out  = hold_full_q;
  assign tx_data_out   = hold_data_q;
  assign grant_out     = grant_q;
  assign busy_out      = (state_q != IDLE);

endmodule
